// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - elastic valid/ready FIFO with fall-through, watermarks and high-water tracking
module stream_fifo #(
  parameter bit          FallThrough       = 1'b0,
  parameter int unsigned DataWidth         = 32,
  parameter int unsigned FifoDepth         = 8,
  parameter int unsigned AlmostFullThresh  = FifoDepth - 1,
  parameter int unsigned AlmostEmptyThresh = 1,
  parameter int unsigned AddrWidth         = $clog2(FifoDepth)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic [DataWidth-1:0] in_data_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic [DataWidth-1:0] out_data_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [AddrWidth:0]   count_o,
  output logic                 almost_full_o,
  output logic                 almost_empty_o,
  output logic [AddrWidth:0]   high_water_o
);

  localparam int unsigned           CntWidth = AddrWidth + 1;
  localparam logic [CntWidth-1:0]   Depth    = CntWidth'(FifoDepth);
  localparam logic [CntWidth-1:0]   AfThr    = CntWidth'(AlmostFullThresh);
  localparam logic [CntWidth-1:0]   AeThr    = CntWidth'(AlmostEmptyThresh);
  localparam logic [AddrWidth-1:0]  LastAddr = AddrWidth'(FifoDepth - 1);

  logic [DataWidth-1:0] mem_q [FifoDepth];
  logic [AddrWidth-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0]  count_q, count_d, hw_q, hw_d;
  logic                 empty, push, pop, bypass, do_push, do_pop;

  always_comb begin
    empty       = (count_q == '0);
    in_ready_o  = (count_q != Depth);
    out_valid_o = !empty || (FallThrough && in_valid_i);
    out_data_o  = (FallThrough && empty) ? in_data_i : mem_q[rd_ptr_q];
    push        = in_valid_i && in_ready_o;
    pop         = out_valid_o && out_ready_i;
    // An empty fall-through FIFO hands the word straight over without touching storage.
    bypass      = FallThrough && empty && push && pop;
    do_push     = push && !bypass;
    do_pop      = pop && !bypass;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == LastAddr) ? '0 : wr_ptr_q + AddrWidth'(1);
    if (do_pop)  rd_ptr_d = (rd_ptr_q == LastAddr) ? '0 : rd_ptr_q + AddrWidth'(1);
    count_d = count_q + CntWidth'(do_push) - CntWidth'(do_pop);
    hw_d    = (count_d > hw_q) ? count_d : hw_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      hw_d     = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FifoDepth; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hw_q     <= '0;
    end else begin
      if (do_push && !clr_i) mem_q[wr_ptr_q] <= in_data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      hw_q     <= hw_d;
    end
  end

  assign count_o        = count_q;
  assign high_water_o   = hw_q;
  assign almost_full_o  = (count_q >= AfThr);
  assign almost_empty_o = (count_q <= AeThr);

  a_params: assert property (@(posedge clk_i)
    FifoDepth >= 2 && AlmostFullThresh >= 1 && AlmostFullThresh <= FifoDepth &&
    AlmostEmptyThresh < FifoDepth);
  a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni) count_q <= Depth);
  a_producer_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    in_valid_i && !in_ready_o |=> !in_valid_i || $stable(in_data_i));

endmodule

// File: tb/tb_stream_fifo.sv
// tb/tb_stream_fifo.sv - queue-model bench for stream_fifo across three configurations
module tb_stream_fifo;

  localparam int DEPTH [3] = '{8, 5, 6};
  localparam bit FT    [3] = '{1'b0, 1'b0, 1'b1};
  localparam int AF    [3] = '{7, 4, 6};
  localparam int AE    [3] = '{1, 2, 0};

  logic        clk, rst_n, clr, ordy;
  logic [31:0] din;
  logic        vin       [3];
  logic        in_ready  [3];
  logic        out_valid [3];
  logic [31:0] out_data  [3];
  logic [3:0]  cnt       [3];
  logic [3:0]  hw        [3];
  logic        af        [3];
  logic        ae        [3];

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_q [3][8];
  int          m_cnt [3];
  int          m_hw  [3];
  bit          stall_any;

  stream_fifo #(.FallThrough(1'b0), .DataWidth(32), .FifoDepth(8),
                .AlmostFullThresh(7), .AlmostEmptyThresh(1)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .in_data_i(din), .in_valid_i(vin[0]),
    .in_ready_o(in_ready[0]), .out_data_o(out_data[0]), .out_valid_o(out_valid[0]),
    .out_ready_i(ordy), .count_o(cnt[0]), .almost_full_o(af[0]), .almost_empty_o(ae[0]),
    .high_water_o(hw[0]));

  stream_fifo #(.FallThrough(1'b0), .DataWidth(32), .FifoDepth(5),
                .AlmostFullThresh(4), .AlmostEmptyThresh(2)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .in_data_i(din), .in_valid_i(vin[1]),
    .in_ready_o(in_ready[1]), .out_data_o(out_data[1]), .out_valid_o(out_valid[1]),
    .out_ready_i(ordy), .count_o(cnt[1]), .almost_full_o(af[1]), .almost_empty_o(ae[1]),
    .high_water_o(hw[1]));

  stream_fifo #(.FallThrough(1'b1), .DataWidth(32), .FifoDepth(6),
                .AlmostFullThresh(6), .AlmostEmptyThresh(0)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .in_data_i(din), .in_valid_i(vin[2]),
    .in_ready_o(in_ready[2]), .out_data_o(out_data[2]), .out_valid_o(out_valid[2]),
    .out_ready_i(ordy), .count_o(cnt[2]), .almost_full_o(af[2]), .almost_empty_o(ae[2]),
    .high_water_o(hw[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d at %0t: got %0h, expected %0h", nm, k, $time, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: each FIFO is an ordered list; head is element 0, pops shift the list.
  initial begin
    stall_any = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int k = 0; k < 3; k++) begin
          m_cnt[k] = 0;
          m_hw[k]  = 0;
        end
      end
      stall_any = 1'b0;
      for (int k = 0; k < 3; k++) begin
        bit          e_rdy, e_vld, psh, pp;
        logic [31:0] e_dat;
        e_rdy = (m_cnt[k] != DEPTH[k]);
        e_vld = (m_cnt[k] != 0) || (FT[k] && vin[k]);
        e_dat = (m_cnt[k] != 0) ? m_q[k][0] : din;
        chk("in_ready", k, 32'(in_ready[k]), 32'(e_rdy));
        chk("out_valid", k, 32'(out_valid[k]), 32'(e_vld));
        chk("count", k, 32'(cnt[k]), m_cnt[k]);
        chk("almost_full", k, 32'(af[k]), 32'(m_cnt[k] >= AF[k]));
        chk("almost_empty", k, 32'(ae[k]), 32'(m_cnt[k] <= AE[k]));
        chk("high_water", k, 32'(hw[k]), m_hw[k]);
        if (e_vld) chk("out_data", k, out_data[k], e_dat);
        if (vin[k] && !e_rdy) stall_any = 1'b1;
        if (rst_n) begin
          psh = vin[k] && e_rdy;
          pp  = e_vld && ordy;
          if (clr) begin
            m_cnt[k] = 0;
            m_hw[k]  = 0;
          end else if (!(FT[k] && m_cnt[k] == 0 && psh && pp)) begin
            if (pp) begin
              for (int j = 0; j < 7; j++) m_q[k][j] = m_q[k][j+1];
              m_cnt[k]--;
            end
            if (psh) begin
              m_q[k][m_cnt[k]] = din;
              m_cnt[k]++;
            end
            if (m_cnt[k] > m_hw[k]) m_hw[k] = m_cnt[k];
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b1; clr = 1'b0; ordy = 1'b0; din = '0;
    for (int k = 0; k < 3; k++) vin[k] = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) cyc();
    for (int k = 0; k < 3; k++) begin
      chk("rst_in_ready", k, 32'(in_ready[k]), 1);
      chk("rst_out_valid", k, 32'(out_valid[k]), 0);
      chk("rst_out_data", k, out_data[k], 0);
      chk("rst_count", k, 32'(cnt[k]), 0);
      chk("rst_af", k, 32'(af[k]), 0);
      chk("rst_ae", k, 32'(ae[k]), 1);
      chk("rst_hw", k, 32'(hw[k]), 0);
    end
    rst_n = 1'b1;
    cyc();

    // Fill depth-8 FIFO with 0x11..0x18, consumer stalled
    for (int i = 0; i < 8; i++) begin
      vin[0] = 1'b1;
      din    = 32'h11 + i;
      cyc();
      #1;
      chk("fill_count", 0, 32'(cnt[0]), i + 1);
      if (i == 5) chk("af_at6", 0, 32'(af[0]), 0);
      if (i == 6) chk("af_at7", 0, 32'(af[0]), 1);
    end
    vin[0] = 1'b0;
    #1;
    chk("full_in_ready", 0, 32'(in_ready[0]), 0);
    chk("full_hw", 0, 32'(hw[0]), 8);

    // Drain in order
    ordy = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_data", 0, out_data[0], 32'h11 + i);
      cyc();
      #1;
    end
    ordy = 1'b0;
    chk("drain_count", 0, 32'(cnt[0]), 0);
    chk("drain_ae", 0, 32'(ae[0]), 1);
    chk("drain_hw", 0, 32'(hw[0]), 8);

    // Zero-latency bypass on the fall-through instance
    vin[2] = 1'b1; din = 32'hA5; ordy = 1'b1;
    #1;
    chk("ft_valid", 2, 32'(out_valid[2]), 1);
    chk("ft_data", 2, out_data[2], 32'hA5);
    cyc();
    vin[2] = 1'b0; ordy = 1'b0;
    #1;
    chk("ft_count", 2, 32'(cnt[2]), 0);
    chk("ft_hw", 2, 32'(hw[2]), 0);

    // Full FIFO with simultaneous push/pop: pop only
    for (int i = 0; i < 8; i++) begin
      vin[0] = 1'b1; din = 32'h21 + i;
      cyc();
    end
    din = 32'h99; ordy = 1'b1;
    #1;
    chk("fullpp_in_ready", 0, 32'(in_ready[0]), 0);
    chk("fullpp_head", 0, out_data[0], 32'h21);
    cyc();
    vin[0] = 1'b0; ordy = 1'b0;
    #1;
    chk("fullpp_count", 0, 32'(cnt[0]), 7);
    chk("fullpp_ready_after", 0, 32'(in_ready[0]), 1);

    // Clear, then build count 3 / hw 6 and clear again with a push in flight
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    #1;
    chk("clr_count", 0, 32'(cnt[0]), 0);
    chk("clr_hw", 0, 32'(hw[0]), 0);
    for (int i = 0; i < 6; i++) begin
      vin[0] = 1'b1; din = 32'h31 + i;
      cyc();
    end
    vin[0] = 1'b0; ordy = 1'b1;
    repeat (3) cyc();
    ordy = 1'b0;
    #1;
    chk("pre_clr_count", 0, 32'(cnt[0]), 3);
    chk("pre_clr_hw", 0, 32'(hw[0]), 6);
    clr = 1'b1; vin[0] = 1'b1; din = 32'hEE;
    cyc();
    clr = 1'b0; vin[0] = 1'b0;
    #1;
    chk("clr2_count", 0, 32'(cnt[0]), 0);
    chk("clr2_hw", 0, 32'(hw[0]), 0);
    chk("clr2_valid", 0, 32'(out_valid[0]), 0);

    // Randomized traffic alternating between filling and draining bias
    for (int c = 0; c < 3000; c++) begin
      int pin;
      pin  = ((c / 250) % 2 == 1) ? 1 : 3;
      clr  = ($urandom_range(0, 79) == 0);
      for (int k = 0; k < 3; k++) vin[k] = ($urandom_range(0, 3) < pin);
      ordy = ($urandom_range(0, 3) >= pin);
      if (!stall_any) din = $urandom;
      cyc();
    end

    // Asynchronous reset mid-burst
    rst_n = 1'b0; clr = 1'b0; ordy = 1'b0;
    for (int k = 0; k < 3; k++) vin[k] = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("arst_in_ready", k, 32'(in_ready[k]), 1);
      chk("arst_out_valid", k, 32'(out_valid[k]), 0);
      chk("arst_count", k, 32'(cnt[k]), 0);
      chk("arst_hw", k, 32'(hw[k]), 0);
      chk("arst_ae", k, 32'(ae[k]), 1);
      chk("arst_af", k, 32'(af[k]), 0);
      if (k < 2) chk("arst_out_data", k, out_data[k], 0);
    end
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (5) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
